// File: rtl/regfile_bypass.sv
// MIPS general-purpose register file: two forwarded read ports, main + link write ports,
// post-reset sequential clear engine. Optional HI/LO registers via `REGFILE_HILO_EN`.
module regfile_bypass #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rreg_a,
    input  logic [ADDR_W-1:0] rreg_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wreg,
    input  logic [DATA_W-1:0] wdata,
    input  logic              store_pc,
    input  logic [DATA_W-1:0] link_pc,
`ifdef REGFILE_HILO_EN
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic [DATA_W-1:0] lo_wdata,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata,
`endif
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              running;
    logic [DATA_W-1:0] link_value;
    logic              link_we;
    logic              main_we;

    assign running    = (state == S_RUN);
    assign busy       = ~running;
    assign link_value = link_pc + DATA_W'(LINK_OFFSET);
    assign link_we    = running && store_pc && (LINK_ADDR != '0);
    // The link port owns LINK_REG when both ports target it in the same cycle.
    assign main_we    = running && reg_write && (wreg != '0) && !(link_we && wreg == LINK_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= ADDR_W'(1);
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) state <= S_RUN;
        end
    end

    // NOTE: the storage array has no reset term; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                regs[cnt] <= '0;
            end else begin
                if (link_we) regs[LINK_ADDR] <= link_value;
                if (main_we) regs[wreg] <= wdata;
            end
        end
    end

    // Forwarded read: returns exactly what the next edge will commit.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (!running || addr == '0)             value = '0;
        else if (link_we && addr == LINK_ADDR)  value = link_value;
        else if (main_we && addr == wreg)       value = wdata;
        return value;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rdata_a = resolve(rreg_a, regs[rreg_a]);
        rdata_b = resolve(rreg_b, regs[rreg_b]);
    end

`ifdef REGFILE_HILO_EN
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst || !running) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            hi_q <= hi_wdata;
            lo_q <= lo_wdata;
        end
    end

    always_comb begin
        hi_rdata = '0;
        lo_rdata = '0;
        if (running) begin
            hi_rdata = hilo_we ? hi_wdata : hi_q;
            lo_rdata = hilo_we ? lo_wdata : lo_q;
        end
    end
`else
    // No HI/LO state in this build.
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rreg_a, rreg_b, wreg;
    logic [31:0] rdata_a, rdata_b, wdata, link_pc;
    logic        reg_write, store_pc, busy;
`ifdef REGFILE_HILO_EN
    logic        hilo_we = 1'b0;
    logic [31:0] hi_wdata = '0, lo_wdata = '0, hi_rdata, lo_rdata;
`endif

    int checks = 0;
    int passes = 0;

    logic [31:0] model [32];
    int          clear_left = 31;

    always #5 clk = ~clk;

    regfile_bypass dut (
        .clk(clk), .rst(rst),
        .rreg_a(rreg_a), .rreg_b(rreg_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .reg_write(reg_write), .wreg(wreg), .wdata(wdata),
        .store_pc(store_pc), .link_pc(link_pc),
`ifdef REGFILE_HILO_EN
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
`endif
        .busy(busy)
    );

    // Reference: a reset starts a 31-edge clear window; when it ends every entry is zero.
    task automatic tick();
        if (rst) begin
            clear_left = 31;
        end else if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else begin
            if (reg_write && wreg != 5'd0) model[wreg] = wdata;
            if (store_pc) model[31] = link_pc + 32'd8;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (clear_left > 0 || addr == 5'd0) return 32'd0;
        if (store_pc && addr == 5'd31)      return link_pc + 32'd8;
        if (reg_write && addr == wreg)      return wdata;
        return model[addr];
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1; reg_write = 1'b1; wreg = 5'd5; wdata = 32'hDEAD;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy);
        else passes++;
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            rreg_a = 5'(n); rreg_b = ~5'(n);
            #1;
            checks++;
            if (rdata_a !== 32'd0 || rdata_b !== 32'd0)
                $display("FAIL clear_read: a=%h b=%h want 0", rdata_a, rdata_b);
            else passes++;
            tick();
            n++;
        end
        checks++;
        if (n !== 31) $display("FAIL clear_length: got %0d edges want 31", n);
        else passes++;
        reg_write = 1'b0; rreg_a = 5'd5; rreg_b = 5'd5;
        #1;
        checks++;
        if (rdata_a !== 32'd0) $display("FAIL reset_r5: got %h want 0", rdata_a);
        else passes++;
    endtask

    task automatic test_write_r0();
        reg_write = 1'b1; wreg = 5'd7; wdata = 32'h12345678;
        tick();
        wreg = 5'd0; wdata = 32'hFFFFFFFF;
        tick();
        reg_write = 1'b0; rreg_a = 5'd7; rreg_b = 5'd0;
        #1;
        checks++;
        if (rdata_a !== 32'h12345678) $display("FAIL write_r7: got %h want 12345678", rdata_a);
        else passes++;
        checks++;
        if (rdata_b !== 32'd0) $display("FAIL read_r0: got %h want 0", rdata_b);
        else passes++;
    endtask

    task automatic test_forward();
        reg_write = 1'b1; wreg = 5'd9; wdata = 32'hA5A5A5A5; rreg_a = 5'd9; rreg_b = 5'd9;
        #1;
        checks++;
        if (rdata_a !== 32'hA5A5A5A5 || rdata_b !== 32'hA5A5A5A5)
            $display("FAIL forward: a=%h b=%h want a5a5a5a5", rdata_a, rdata_b);
        else passes++;
        tick();
        reg_write = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 32'hA5A5A5A5) $display("FAIL forward_commit: got %h want a5a5a5a5", rdata_a);
        else passes++;
    endtask

    task automatic test_link_conflict();
        store_pc = 1'b1; link_pc = 32'hBFC00100;
        reg_write = 1'b1; wreg = 5'd31; wdata = 32'h1; rreg_a = 5'd31; rreg_b = 5'd31;
        #1;
        checks++;
        if (rdata_a !== 32'hBFC00108 || rdata_b !== 32'hBFC00108)
            $display("FAIL link_conflict_fwd: a=%h b=%h want bfc00108", rdata_a, rdata_b);
        else passes++;
        tick();
        store_pc = 1'b0; reg_write = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 32'hBFC00108) $display("FAIL link_conflict_commit: got %h want bfc00108", rdata_a);
        else passes++;
    endtask

    task automatic test_link_wrap();
        store_pc = 1'b1; link_pc = 32'hFFFFFFFC; rreg_a = 5'd31;
        #1;
        checks++;
        if (rdata_a !== 32'h4) $display("FAIL link_wrap_fwd: got %h want 00000004", rdata_a);
        else passes++;
        tick();
        store_pc = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 32'h4) $display("FAIL link_wrap_commit: got %h want 00000004", rdata_a);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        for (int i = 0; i < 300; i++) begin
            reg_write = ($urandom_range(0, 3) != 0);
            store_pc  = ($urandom_range(0, 5) == 0);
            wreg      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            wdata     = $urandom;
            link_pc   = $urandom;
            case ($urandom_range(0, 5))
                0, 1:    rreg_a = wreg;
                2:       rreg_a = 5'd31;
                default: rreg_a = 5'($urandom_range(0, 31));
            endcase
            rreg_b = ($urandom_range(0, 2) == 0) ? rreg_a : 5'($urandom_range(0, 31));
            #1;
            ea = exp_read(rreg_a);
            eb = exp_read(rreg_b);
            checks++;
            if (rdata_a !== ea || rdata_b !== eb)
                $display("FAIL random[%0d]: a(r%0d)=%h want %h, b(r%0d)=%h want %h",
                         i, rreg_a, rdata_a, ea, rreg_b, rdata_b, eb);
            else passes++;
            tick();
        end
        reg_write = 1'b0; store_pc = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0; reg_write = 1'b1; wreg = 5'd12; wdata = $urandom;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", busy);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 31) $display("FAIL restart_length: got %0d edges want 31", n);
        else passes++;
        reg_write = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rreg_a = 5'(a); rreg_b = 5'(31 - a);
            #1;
            checks++;
            if (rdata_a !== 32'd0 || rdata_b !== 32'd0)
                $display("FAIL post_clear_r%0d: a=%h b=%h want 0", a, rdata_a, rdata_b);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; rreg_a = '0; rreg_b = '0; reg_write = 1'b0; wreg = '0;
        wdata = '0; store_pc = 1'b0; link_pc = '0;
        test_reset();
        test_write_r0();
        test_forward();
        test_link_conflict();
        test_link_wrap();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised general-purpose register file for the MIPS core; successor to the single-write-port, unforwarded register file.
- Two combinational read ports with write-to-read forwarding.
- One main write port plus a dedicated link-write port for jal/jalr/bgezal.
- Post-reset sequential clear engine zeroes every entry and reports busy while it runs. Sits in the ID stage, fed by WB.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, address width; depth = 2**ADDR_W entries.
- LINK_REG, 31, index written by the link port.
- LINK_OFFSET, 8, constant added to link_pc (return address = pc + LINK_OFFSET).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- rreg_a  input  ADDR_W  read port A address.
- rreg_b  input  ADDR_W  read port B address.
- rdata_a  output  DATA_W  read port A data (combinational).
- rdata_b  output  DATA_W  read port B data (combinational).
- reg_write  input  1  main write enable.
- wreg  input  ADDR_W  main write address.
- wdata  input  DATA_W  main write data.
- store_pc  input  1  link write enable.
- link_pc  input  DATA_W  instruction address of the linking branch.
- busy  output  1  clear engine active; stall the pipeline while high.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Entry 0 is hard-wired zero:
  - Writes to address 0 from either port are discarded.
  - Reads of address 0 return 0, including via forwarding.
- State machine, busy registered:
  - CLEAR: busy=1. While rst=1: state forced to CLEAR, clear counter cnt forced to 1, no entry written. With rst=0: each edge writes 0 to entry cnt and increments cnt. The edge that clears entry 2**ADDR_W-1 moves to RUN. The full clear takes 2**ADDR_W-1 cycles after rst falls.
  - RUN: busy=0; normal read/write operation.
  - rst asserted in any state, including mid-clear, returns to CLEAR with cnt=1 on the next edge. The clear restarts from entry 1.
  - Reset value: busy=1 from the first reset edge. A reset is required after power-up.
- In CLEAR:
  - reg_write and store_pc are ignored.
  - rdata_a and rdata_b = 0.
- Write, RUN only, on the rising edge:
  - Link value = link_pc + LINK_OFFSET, truncated to DATA_W (wrap-around, no carry out).
  - store_pc=1 writes the link value to LINK_REG.
  - reg_write=1 with wreg!=0 writes wdata to entry wreg.
  - Both enabled with wreg==LINK_REG: the link port wins and wdata is dropped.
  - Both enabled with different targets: both writes commit in the same cycle.
- Read, RUN only, combinational, zero latency. Priority for each port:
  1. Address 0 returns 0.
  2. Address LINK_REG with store_pc=1 returns the link value.
  3. Address == wreg with reg_write=1 returns wdata.
  4. Otherwise the stored entry.
  - Forwarding therefore returns exactly what the next edge commits.
  - Both read ports may address the same entry; each resolves independently.

Optional Feature:
- Macro: REGFILE_HILO_EN.
- Defined: adds HI/LO multiply-divide registers with these ports:
  - hilo_we input 1.
  - hi_wdata input DATA_W.
  - lo_wdata input DATA_W.
  - hi_rdata output DATA_W.
  - lo_rdata output DATA_W.
- HI/LO behaviour:
  - Both registers are cleared to 0 on the first CLEAR edge.
  - Writes occur in RUN only.
  - Reads forward hi_wdata/lo_wdata when hilo_we=1.
  - Reads return 0 while busy=1.
- Undefined: these ports and registers do not exist; the rest of the behaviour is unchanged.

Test Plan:
- Reset/clear: hold rst=1 for 3 cycles with reg_write=1, wreg=5, wdata=32'hDEAD, then release.
  - busy stays 1 for exactly 31 edges, then 0.
  - rdata of every address is 0 throughout.
  - Entry 5 reads 0 afterwards.
- Write/read and r0: in RUN, write 32'h12345678 to r7, then write 32'hFFFFFFFF to r0.
  - Next cycle, rreg_a=7 gives 32'h12345678.
  - rreg_b=0 gives 0.
- Forwarding: reg_write=1, wreg=9, wdata=32'hA5A5A5A5 with rreg_a=rreg_b=9 in the same cycle.
  - Both outputs are 32'hA5A5A5A5 before the edge.
  - Entry 9 holds 32'hA5A5A5A5 after the edge.
- Link conflict: store_pc=1, link_pc=32'hBFC00100, reg_write=1, wreg=31, wdata=32'h1.
  - rdata_a(rreg_a=31) = 32'hBFC00108 both during the cycle and after it.
- Link wrap: link_pc=32'hFFFFFFFC.
  - r31 = 32'h00000004.
- Reset mid-clear: assert rst=1 for 1 cycle after 10 clear cycles.
  - busy remains 1 for a further 31 edges after the release.
  - All entries read 0 once busy falls.
